vector_csr_requester: RTL and testbench

//  Initiator side of priv_ext_if for the vector CSR file. Executes vsetvli/vsetivli/vsetvl and vector CSR reads.
//  For vset* it computes VLMAX from the new vtype, clamps AVL, drives the vsetvl/vkeepvl/new_vtype strobes,

---
 rtl/vector_csr_requester_if.sv | 44 ++++
 rtl/vector_csr_requester.sv | 194 +++++++++++++++++++
 tb/tb_vector_csr_requester.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_csr_requester_if.sv
// Request/response channels plus the priv_ext_if and priv-internal strobes of vector_csr_requester.
// master = the requester block; slave = execute-stage producer/consumer and the priv block.
interface vector_csr_requester_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned OP_W   = 2;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [CSR_AW-1:0] req_csr_addr;
  logic [XLEN-1:0]   req_avl;
  logic              req_rs1_x0;
  logic              req_rd_x0;
  logic [XLEN-1:0]   req_vtype;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_err;

  logic [CSR_AW-1:0] csr_addr;
  logic              csr_active;
  logic [XLEN-1:0]   value_in;
  logic [XLEN-1:0]   value_out;
  logic              ack;
  logic              vsetvl;
  logic              vkeepvl;
  logic [XLEN-1:0]   new_vtype;

  modport master (
    input  req_valid, req_op, req_csr_addr, req_avl, req_rs1_x0, req_rd_x0, req_vtype,
    input  resp_ready, value_out, ack,
    output req_ready, resp_valid, resp_data, resp_err,
    output csr_addr, csr_active, value_in, vsetvl, vkeepvl, new_vtype
  );

  modport slave (
    output req_valid, req_op, req_csr_addr, req_avl, req_rs1_x0, req_rd_x0, req_vtype,
    output resp_ready, value_out, ack,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  csr_addr, csr_active, value_in, vsetvl, vkeepvl, new_vtype
  );
endinterface

// File: rtl/vector_csr_requester.sv
// Initiator side of priv_ext_if for the vector CSR file: executes vset* and vector CSR reads.
// Optional macro VSET_VILL_CHECK_EN: flag illegal vtype requests as vill with vl forced to 0.
module vector_csr_requester #(
  parameter int unsigned VLEN        = 128,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input logic                    CLK,
  input logic                    RST,
  vector_csr_requester_if.master bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CSR_AW-1:0] VL_ADDR     = 12'hC20;
  localparam logic [1:0]        OP_VSETIVLI = 2'd1;
  localparam logic [1:0]        OP_CSRR     = 2'd3;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
  logic              csr_active_q, csr_active_d;
  logic [XLEN-1:0]   value_in_q, value_in_d;
  logic              vsetvl_q, vsetvl_d;
  logic              vkeepvl_q, vkeepvl_d;
  logic [XLEN-1:0]   new_vtype_q, new_vtype_d;

  logic [2:0]        sew;
  logic [2:0]        lmul;
  logic [XLEN-1:0]   vlmax_base;
  logic [XLEN-1:0]   vlmax;
  logic [XLEN-1:0]   avl;
  logic [XLEN-1:0]   vl_clamped;
  logic              keep;
  logic [XLEN-1:0]   vtype_eff;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.csr_addr   = csr_addr_q;
  assign bus.csr_active = csr_active_q;
  assign bus.value_in   = value_in_q;
  assign bus.vsetvl     = vsetvl_q;
  assign bus.vkeepvl    = vkeepvl_q;
  assign bus.new_vtype  = new_vtype_q;

  // VLMAX / AVL / clamped vl for the incoming request, latched at accept
  always_comb begin
    sew        = bus.req_vtype[5:3];
    lmul       = bus.req_vtype[2:0];
    vlmax_base = XLEN'(VLEN) >> (4'd3 + {1'b0, sew});
    case (lmul)
      3'b000:  vlmax = vlmax_base;
      3'b001:  vlmax = vlmax_base << 1;
      3'b010:  vlmax = vlmax_base << 2;
      3'b011:  vlmax = vlmax_base << 3;
      3'b111:  vlmax = vlmax_base >> 1;
      3'b110:  vlmax = vlmax_base >> 2;
      3'b101:  vlmax = vlmax_base >> 3;
      default: vlmax = '0;
    endcase

    keep = 1'b0;
    avl  = bus.req_avl;
    if (bus.req_op == OP_VSETIVLI) begin
      avl = {27'd0, bus.req_avl[4:0]};
    end else if (bus.req_rs1_x0) begin
      avl  = '1;
      keep = bus.req_rd_x0;
    end
    vl_clamped = (avl < vlmax) ? avl : vlmax;
    vtype_eff  = bus.req_vtype;
`ifdef VSET_VILL_CHECK_EN
    if ((sew > 3'b010) || bus.req_vtype[6] || bus.req_vtype[7] ||
        (lmul == 3'b100) || (vlmax == '0)) begin
      vtype_eff  = 32'h8000_0000;
      vl_clamped = '0;
      keep       = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    csr_addr_d   = csr_addr_q;
    csr_active_d = csr_active_q;
    value_in_d   = value_in_q;
    vsetvl_d     = vsetvl_q;
    vkeepvl_d    = vkeepvl_q;
    new_vtype_d  = new_vtype_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d      = ST_ISSUE;
          cnt_d        = '0;
          req_ready_d  = 1'b0;
          csr_active_d = 1'b1;
          if (bus.req_op == OP_CSRR) begin
            csr_addr_d  = bus.req_csr_addr;
            vsetvl_d    = 1'b0;
            vkeepvl_d   = 1'b0;
            value_in_d  = '0;
            new_vtype_d = '0;
          end else begin
            csr_addr_d  = VL_ADDR;
            vsetvl_d    = 1'b1;
            vkeepvl_d   = keep;
            value_in_d  = vl_clamped;
            new_vtype_d = vtype_eff;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.ack || (cnt_q == CNT_LAST)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !bus.ack;
          if (!bus.ack)
            resp_data_d = '0;
          else if (vsetvl_q && !vkeepvl_q)
            resp_data_d = value_in_q;
          else
            resp_data_d = bus.value_out;
          csr_active_d = 1'b0;
          csr_addr_d   = '0;
          vsetvl_d     = 1'b0;
          vkeepvl_d    = 1'b0;
          value_in_d   = '0;
          new_vtype_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_data_d  = '0;
          resp_err_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      csr_addr_q   <= '0;
      csr_active_q <= 1'b0;
      value_in_q   <= '0;
      vsetvl_q     <= 1'b0;
      vkeepvl_q    <= 1'b0;
      new_vtype_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      csr_addr_q   <= csr_addr_d;
      csr_active_q <= csr_active_d;
      value_in_q   <= value_in_d;
      vsetvl_q     <= vsetvl_d;
      vkeepvl_q    <= vkeepvl_d;
      new_vtype_q  <= new_vtype_d;
    end
  end
endmodule

// File: tb/tb_vector_csr_requester.sv
// Directed scoreboard bench for vector_csr_requester (VLEN=128, ACK_TIMEOUT=8).
module tb_vector_csr_requester;
  localparam logic [11:0] VL_ADDR     = 12'hC20;
  localparam logic [11:0] VLENB_ADDR  = 12'hC22;
  localparam logic [1:0]  OP_VSETVLI  = 2'd0;
  localparam logic [1:0]  OP_VSETIVLI = 2'd1;
  localparam logic [1:0]  OP_VSETVL   = 2'd2;
  localparam logic [1:0]  OP_CSRR     = 2'd3;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  vector_csr_requester_if bus();

  vector_csr_requester #(.VLEN(128), .ACK_TIMEOUT(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a response, compares it against the scoreboard, holds it, then accepts it.
  task automatic wait_resp(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.resp_valid && n < 16) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    if (sb.size() == 0) begin
      e = '0;
      chk({tag, ".sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      chk({tag, ".resp_data"}, bus.resp_data, e.data);
      chk({tag, ".resp_err"}, 32'(bus.resp_err), 32'(e.err));
      chk({tag, ".resp_held"}, 32'(bus.resp_valid), 32'd1);
      if (h < hold) @(negedge CLK);
    end
    bus.resp_ready = 1'b1;
    @(negedge CLK);
    bus.resp_ready = 1'b0;
    chk({tag, ".resp_done"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [11:0] caddr,
                        input logic [31:0] avl, input logic rs1x0, input logic rdx0,
                        input logic [31:0] vtype, input logic [31:0] vout, input int ack_dly,
                        input logic [11:0] e_addr, input logic e_vset, input logic e_keep,
                        input logic [31:0] e_vtype, input logic [31:0] e_vin,
                        input logic chk_vin, input logic [31:0] e_data);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_csr_addr = caddr;
    bus.req_avl      = avl;
    bus.req_rs1_x0   = rs1x0;
    bus.req_rd_x0    = rdx0;
    bus.req_vtype    = vtype;
    bus.value_out    = vout;
    sb.push_back('{data: e_data, err: 1'b0});
    @(negedge CLK);
    bus.req_valid    = 1'b0;
    bus.req_avl      = 32'hFFFF_FFFF;
    bus.req_vtype    = 32'h0000_00FF;
    bus.req_csr_addr = 12'hFFF;
    for (int i = 0; i <= ack_dly; i++) begin
      chk({tag, ".csr_active"}, 32'(bus.csr_active), 32'd1);
      if (i == 0) begin
        chk({tag, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ".csr_addr"}, 32'(bus.csr_addr), 32'(e_addr));
        chk({tag, ".vsetvl"}, 32'(bus.vsetvl), 32'(e_vset));
        chk({tag, ".vkeepvl"}, 32'(bus.vkeepvl), 32'(e_keep));
        if (e_vset) chk({tag, ".new_vtype"}, bus.new_vtype, e_vtype);
        if (chk_vin) chk({tag, ".value_in"}, bus.value_in, e_vin);
      end
      if (i == ack_dly) bus.ack = 1'b1;
      @(negedge CLK);
      bus.ack = 1'b0;
    end
    chk({tag, ".active_dropped"}, 32'(bus.csr_active), 32'd0);
    wait_resp(tag, 0);
  endtask

  initial begin
    int n;
    RST              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_op       = '0;
    bus.req_csr_addr = '0;
    bus.req_avl      = '0;
    bus.req_rs1_x0   = 1'b0;
    bus.req_rd_x0    = 1'b0;
    bus.req_vtype    = '0;
    bus.resp_ready   = 1'b0;
    bus.value_out    = '0;
    bus.ack          = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.csr_active", 32'(bus.csr_active), 32'd0);
    chk("rst.vsetvl", 32'(bus.vsetvl), 32'd0);
    chk("rst.value_in", bus.value_in, 32'd0);
    chk("rst.new_vtype", bus.new_vtype, 32'd0);
    chk("rst.resp_data", bus.resp_data, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    do_req("vsetvli_e32m1", OP_VSETVLI, 12'h000, 32'd100, 1'b0, 1'b0, 32'h10, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h10, 32'd4, 1'b1, 32'd4);
    do_req("vsetvli_e32m2", OP_VSETVLI, 12'h000, 32'd3, 1'b0, 1'b0, 32'h11, 32'h55, 2,
           VL_ADDR, 1'b1, 1'b0, 32'h11, 32'd3, 1'b1, 32'd3);
    do_req("vsetivli_e8m1", OP_VSETIVLI, 12'h000, 32'h0000_00FF, 1'b1, 1'b1, 32'h00, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h00, 32'd16, 1'b1, 32'd16);
    do_req("vsetvl_x0_e8m8", OP_VSETVL, 12'h000, 32'd5, 1'b1, 1'b0, 32'h03, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h03, 32'd128, 1'b1, 32'd128);
    do_req("vsetvli_keep", OP_VSETVLI, 12'h000, 32'd1, 1'b1, 1'b1, 32'h10, 32'd7, 1,
           VL_ADDR, 1'b1, 1'b1, 32'h10, 32'd0, 1'b0, 32'd7);
    do_req("csrr_vlenb", OP_CSRR, VLENB_ADDR, 32'd99, 1'b0, 1'b0, 32'h10, 32'd16, 0,
           VLENB_ADDR, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 32'd16);
    do_req("vsetvli_e8mf2", OP_VSETVLI, 12'h000, 32'd100, 1'b0, 1'b0, 32'h07, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h07, 32'd8, 1'b1, 32'd8);
    do_req("ack_last_cycle", OP_VSETVLI, 12'h000, 32'd5, 1'b0, 1'b0, 32'h08, 32'h55, 7,
           VL_ADDR, 1'b1, 1'b0, 32'h08, 32'd5, 1'b1, 32'd5);
`ifdef VSET_VILL_CHECK_EN
    do_req("e64m1_vill", OP_VSETVLI, 12'h000, 32'd100, 1'b0, 1'b0, 32'h18, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b1, 32'd0);
    do_req("lmul_rsvd_vill", OP_VSETVLI, 12'h000, 32'd10, 1'b0, 1'b0, 32'h04, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b1, 32'd0);
`else
    do_req("e64m1", OP_VSETVLI, 12'h000, 32'd100, 1'b0, 1'b0, 32'h18, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h18, 32'd2, 1'b1, 32'd2);
    do_req("lmul_rsvd", OP_VSETVLI, 12'h000, 32'd10, 1'b0, 1'b0, 32'h04, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h04, 32'd0, 1'b1, 32'd0);
`endif

    // No ack: eight ISSUE cycles, then an error response held across a stalled consumer
    chk("to.req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_VSETVLI;
    bus.req_avl    = 32'd100;
    bus.req_vtype  = 32'h10;
    bus.req_rs1_x0 = 1'b0;
    bus.req_rd_x0  = 1'b0;
    bus.value_out  = 32'h1234;
    sb.push_back('{data: 32'd0, err: 1'b1});
    @(negedge CLK);
    bus.req_op = OP_CSRR;
    n = 0;
    while (bus.csr_active && n < 20) begin
      if (n == 0) chk("to.req_ready_issue", 32'(bus.req_ready), 32'd0);
      n++;
      @(negedge CLK);
    end
    chk("to.active_cycles", 32'(n), 32'd8);
    chk("to.req_ready_resp", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_resp("to", 5);

    // Reset while ISSUE is pending drops csr_active without waiting for a clock
    bus.req_valid = 1'b1;
    bus.req_op    = OP_VSETVLI;
    bus.req_avl   = 32'd100;
    bus.req_vtype = 32'h10;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("rst_mid.active", 32'(bus.csr_active), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid.active_dropped", 32'(bus.csr_active), 32'd0);
    chk("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid.vsetvl", 32'(bus.vsetvl), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid.no_resp", 32'(bus.resp_valid), 32'd0);
    do_req("after_rst", OP_VSETVLI, 12'h000, 32'd100, 1'b0, 1'b0, 32'h10, 32'h55, 0,
           VL_ADDR, 1'b1, 1'b0, 32'h10, 32'd4, 1'b1, 32'd4);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
